// File: rtl/encoder32to5_drain_if.sv
// Handshake bundle between a 32-line request source and the sequential encoder.
// The load side carries the request vector in; the out side carries one binary index per transfer.
interface encoder32to5_drain_if;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] req;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  idx;
    logic [5:0]  count;
    logic        done;

    modport slave (
        input  load_valid,
        input  req,
        input  out_ready,
        output load_ready,
        output out_valid,
        output idx,
        output count,
        output done
    );

    modport master (
        output load_valid,
        output req,
        output out_ready,
        input  load_ready,
        input  out_valid,
        input  idx,
        input  count,
        input  done
    );
endinterface

// File: rtl/encoder32to5_drain.sv
// Captures a 32-bit request vector and emits the index of each set bit, one per out handshake, in fixed priority order.
// Latency: first index one cycle after the load; backpressure: out_ready low holds idx/count; loads accepted only when idle.
module encoder32to5_drain #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    encoder32to5_drain_if.slave         bus
);

    logic [31:0] pending_q, pending_d;
    logic [5:0]  count_q,   count_d;
    logic        done_q,    done_d;

    logic        load_rdy;
    logic        out_vld;
    logic        load_acc;
    logic        pop_acc;
    logic [4:0]  idx_w;
    logic [5:0]  req_popcnt;
    logic [31:0] clr_mask;

    assign out_vld  = (pending_q != 32'd0);
    assign load_rdy = ~out_vld;
    assign load_acc = bus.load_valid & load_rdy;
    assign pop_acc  = out_vld & bus.out_ready;

    // Last assignment in the scan wins, so scan away from the preferred end.
    always_comb begin
        idx_w = 5'd0;
        if (LSB_FIRST) begin
            for (int i = 31; i >= 0; i--) begin
                if (pending_q[i]) begin
                    idx_w = 5'(i);
                end
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (pending_q[i]) begin
                    idx_w = 5'(i);
                end
            end
        end
    end

    always_comb begin
        req_popcnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            req_popcnt = req_popcnt + {5'd0, bus.req[i]};
        end
    end

    assign clr_mask = 32'd1 << idx_w;

    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        done_d    = 1'b0;
        if (load_acc) begin
            pending_d = bus.req;
            count_d   = req_popcnt;
            done_d    = (bus.req == 32'd0);
        end else if (pop_acc) begin
            pending_d = pending_q & ~clr_mask;
            count_d   = count_q - 6'd1;
            done_d    = (pending_d == 32'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 32'd0;
            count_q   <= 6'd0;
            done_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

    assign bus.load_ready = load_rdy;
    assign bus.out_valid  = out_vld;
    assign bus.idx        = idx_w;
    assign bus.count      = count_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_encoder32to5_drain.sv
// Directed bench for both priority orders of the sequential 32-to-5 encoder.
module tb_encoder32to5_drain;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    encoder32to5_drain_if ifa ();
    encoder32to5_drain_if ifb ();

    encoder32to5_drain #(.LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    encoder32to5_drain #(.LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_a [4];
        int exp_b [4];
        int pops;
        logic rdy;
        exp_a = '{0, 2, 5, 31};
        exp_b = '{31, 5, 2, 0};

        ifa.load_valid = 1'b0; ifa.req = 32'd0; ifa.out_ready = 1'b0;
        ifb.load_valid = 1'b0; ifb.req = 32'd0; ifb.out_ready = 1'b0;

        // Reset state
        step(); step();
        chk("rst_load_ready", 32'(ifa.load_ready), 32'd1);
        chk("rst_out_valid",  32'(ifa.out_valid),  32'd0);
        chk("rst_idx",        32'(ifa.idx),        32'd0);
        chk("rst_count",      32'(ifa.count),      32'd0);
        chk("rst_done",       32'(ifa.done),       32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_done",  32'(ifa.done),       32'd0);

        // Sparse drain, lowest bit first
        ifa.load_valid = 1'b1; ifa.req = 32'h8000_0025; ifa.out_ready = 1'b1;
        step();
        ifa.load_valid = 1'b0; ifa.req = 32'd0;
        chk("sparse_load_ready", 32'(ifa.load_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("sparse_valid", 32'(ifa.out_valid), 32'd1);
            chk("sparse_idx",   32'(ifa.idx),       32'(exp_a[i]));
            chk("sparse_count", 32'(ifa.count),     32'(4 - i));
            chk("sparse_done",  32'(ifa.done),      32'd0);
            step();
        end
        chk("sparse_end_valid", 32'(ifa.out_valid),  32'd0);
        chk("sparse_end_done",  32'(ifa.done),       32'd1);
        chk("sparse_end_lrdy",  32'(ifa.load_ready), 32'd1);
        chk("sparse_end_idx",   32'(ifa.idx),        32'd0);
        ifa.out_ready = 1'b0;
        step();
        chk("sparse_done_drop", 32'(ifa.done), 32'd0);

        // Full vector under backpressure: out_ready high every third cycle
        ifa.load_valid = 1'b1; ifa.req = 32'hFFFF_FFFF;
        step();
        ifa.load_valid = 1'b0; ifa.req = 32'd0;
        chk("full_count", 32'(ifa.count), 32'd32);
        pops = 0;
        for (int c = 0; c < 150; c++) begin
            if (pops == 32) break;
            chk("full_idx",   32'(ifa.idx),   32'(pops));
            chk("full_cnt",   32'(ifa.count), 32'(32 - pops));
            chk("full_done0", 32'(ifa.done),  32'd0);
            rdy = (c % 3 == 0);
            ifa.out_ready = rdy;
            step();
            if (rdy) pops++;
        end
        chk("full_pops",      32'(pops),           32'd32);
        chk("full_end_done",  32'(ifa.done),       32'd1);
        chk("full_end_count", 32'(ifa.count),      32'd0);
        chk("full_end_valid", 32'(ifa.out_valid),  32'd0);
        ifa.out_ready = 1'b0;
        step();
        chk("full_done_drop", 32'(ifa.done), 32'd0);

        // Load of zero
        ifa.load_valid = 1'b1; ifa.req = 32'd0;
        step();
        ifa.load_valid = 1'b0;
        chk("zero_valid", 32'(ifa.out_valid),  32'd0);
        chk("zero_done",  32'(ifa.done),       32'd1);
        chk("zero_lrdy",  32'(ifa.load_ready), 32'd1);
        step();
        chk("zero_done_drop", 32'(ifa.done), 32'd0);

        // load_valid held during a drain, then accepted right after the last pop
        ifa.load_valid = 1'b1; ifa.req = 32'h0000_0003;
        step();
        ifa.req = 32'hFFFF_0000;
        step();
        chk("hold_count", 32'(ifa.count), 32'd2);
        chk("hold_idx",   32'(ifa.idx),   32'd0);
        ifa.out_ready = 1'b1;
        step();
        chk("hold_pop_idx",   32'(ifa.idx),   32'd1);
        chk("hold_pop_count", 32'(ifa.count), 32'd1);
        step();
        chk("hold_last_done", 32'(ifa.done),       32'd1);
        chk("hold_last_lrdy", 32'(ifa.load_ready), 32'd1);
        ifa.out_ready = 1'b0;
        step();
        ifa.load_valid = 1'b0;
        chk("reload_count", 32'(ifa.count),     32'd16);
        chk("reload_idx",   32'(ifa.idx),       32'd16);
        chk("reload_valid", 32'(ifa.out_valid), 32'd1);
        chk("reload_done",  32'(ifa.done),      32'd0);
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) step();
        ifa.out_ready = 1'b0;
        chk("reload_drain_done", 32'(ifa.done), 32'd1);
        step();

        // Reset mid-drain, asserted between edges
        ifa.load_valid = 1'b1; ifa.req = 32'h0000_00F0;
        step();
        ifa.load_valid = 1'b0; ifa.req = 32'd0; ifa.out_ready = 1'b1;
        step();
        ifa.out_ready = 1'b0;
        chk("mid_idx",   32'(ifa.idx),   32'd5);
        chk("mid_count", 32'(ifa.count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(ifa.out_valid),  32'd0);
        chk("async_count", 32'(ifa.count),      32'd0);
        chk("async_lrdy",  32'(ifa.load_ready), 32'd1);
        chk("async_idx",   32'(ifa.idx),        32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("async_no_done1", 32'(ifa.done), 32'd0);
        step();
        chk("async_no_done2", 32'(ifa.done), 32'd0);

        // Highest bit first on the second instance
        ifb.load_valid = 1'b1; ifb.req = 32'h8000_0025; ifb.out_ready = 1'b1;
        step();
        ifb.load_valid = 1'b0; ifb.req = 32'd0;
        for (int i = 0; i < 4; i++) begin
            chk("msb_idx",   32'(ifb.idx),   32'(exp_b[i]));
            chk("msb_count", 32'(ifb.count), 32'(4 - i));
            step();
        end
        chk("msb_end_done",  32'(ifb.done),      32'd1);
        chk("msb_end_valid", 32'(ifb.out_valid), 32'd0);
        ifb.out_ready = 1'b0;
        step();
        chk("msb_done_drop", 32'(ifb.done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/encoder32to5_drain.md
# encoder32to5_drain

Sequential 32-to-5 encoder: the inverse of the 5-to-32 one-hot decoder used for register and line selection. It captures a 32-bit request vector and emits the 5-bit index of every set bit, one index per accepted handshake, in fixed priority order. It sits between any 32-line pending or request bank (interrupt lines, register write-mask scan, cache-way hit vector) and logic that consumes one binary index at a time.

## Interface
Parameters:
- LSB_FIRST, 1, priority order. 1 emits bit 0 first and ascends; 0 emits bit 31 first and descends.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- load_valid  input  1  request to capture `req`.
- load_ready  output  1  high when the block can accept a load. Equals (pending == 0).
- req  input  32  request vector, sampled on an accepted load.
- out_valid  output  1  an index is being presented. Equals (pending != 0).
- out_ready  input  1  consumer accepts `idx` this cycle.
- idx  output  5  index of the highest-priority set bit of `pending`. 0 when `out_valid` is 0.
- count  output  6  number of set bits remaining in `pending`, range 0..32.
- done  output  1  one-cycle pulse marking the end of a drain.

## Operation
- State consists of the following registers: pending[31:0], count[5:0], done.
- Reset (rst_n low, asynchronous):
  - pending = 0, count = 0, done = 0.
  - As a result, load_ready = 1, out_valid = 0, idx = 0.
- Load: when load_valid & load_ready are high at an edge:
  - pending <= req.
  - count <= popcount(req).
- Pop: when out_valid & out_ready are high at an edge:
  - The bit at `idx` in pending is cleared.
  - count decrements by 1.
- Load and pop are mutually exclusive by construction, because load_ready = ~out_valid. A cycle in which load_valid is high while load_ready is low has no effect; the load is not queued.
- idx is a pure function of the registered `pending`. There is no combinational path from req, load_valid or out_ready to idx or out_valid.
- done is registered and high for exactly one cycle after either of these edges:
  - a pop that clears the last set bit (pending goes nonzero to zero);
  - an accepted load with req = 0.
- The block has no other states. "Idle" means pending == 0; "draining" means pending != 0.
- Reset asserted mid-drain discards all remaining pending bits immediately. No done pulse is produced.

## Timing
- Load to first index: an accepted load at edge N gives out_valid = 1 and a valid idx/count in the cycle after edge N (latency 1).
- Throughput: one index per cycle while out_ready is held high. A vector with k set bits drains in k cycles.
- Last pop at edge M:
  - In the cycle after edge M: out_valid = 0, load_ready = 1, done = 1.
  - A new load may be accepted at edge M+1. done drops after edge M+1.
- Backpressure: with out_ready low, idx, out_valid and count hold unchanged indefinitely.
- out_ready high while out_valid is low has no effect.
- Edge cases:
  - Single-bit vector: emits one index, then done.
  - req = 32'hFFFFFFFF: count = 32 (needs 6 bits, no overflow), then 32 pops.

## Test plan
- Reset: hold rst_n low, then release → load_ready = 1, out_valid = 0, idx = 0, count = 0, done = 0. Drop rst_n asynchronously between edges → outputs clear before the next edge.
- Sparse drain, LSB_FIRST = 1: load req = 32'h8000_0025 with out_ready held high → idx sequence 0, 2, 5, 31 on consecutive cycles; count sequence 4, 3, 2, 1; done pulses exactly once, in the cycle after the pop of 31; load_ready returns to 1.
- Priority reversal, LSB_FIRST = 0: same vector → idx sequence 31, 5, 2, 0.
- Full vector and backpressure: load 32'hFFFF_FFFF → count = 32. Toggle out_ready 1, 0, 0, 1, … → idx advances only on cycles with out_ready high. After 32 accepts, count = 0 and done pulses.
- Protocol edges:
  - load of 0 → out_valid stays 0 and done pulses one cycle later.
  - load_valid held high during a drain → pending is unchanged.
  - load_valid high on the cycle after the last pop → the new vector is accepted.
- Reset mid-drain: load 32'h0000_00F0, pop once, assert rst_n → pending clears, count = 0, out_valid = 0, and no done pulse follows.
